// File: rtl/router_vc_input_buffer_if.sv
// Port bundle for the router VC input stage.
// Upstream flit input and credit return, downstream flit output with credit and lock inputs.
// The DUT connects to the slave modport and the driver connects to the master modport.
interface router_vc_input_buffer_if #(
  parameter int DATA_W = 35,
  parameter int NUM_VC = 2,
  parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
  // Upstream side
  logic [DATA_W-1:0] IDATA;
  logic              IVALID;
  logic [VC_W-1:0]   IVCH;
  logic [NUM_VC-1:0] OACK;
  logic [NUM_VC-1:0] ORDY;
  logic [NUM_VC-1:0] OLCK;

  // Downstream side
  logic [DATA_W-1:0] ODATA;
  logic              OVALID;
  logic [VC_W-1:0]   OVCH;
  logic [NUM_VC-1:0] IACK;
  logic [NUM_VC-1:0] ILCK;

  logic              ERR;

  modport master (
    output IDATA, IVALID, IVCH, IACK, ILCK,
    input  OACK, ORDY, OLCK, ODATA, OVALID, OVCH, ERR
  );

  modport slave (
    input  IDATA, IVALID, IVCH, IACK, ILCK,
    output OACK, ORDY, OLCK, ODATA, OVALID, OVCH, ERR
  );
endinterface

// File: rtl/router_vc_input_buffer.sv
// Per-port router input stage: one FIFO per virtual channel, packet lock tracking,
// round-robin VC arbitration and downstream credit counting.
// Flit format: bit DATA_W-1 is the head flag and bit DATA_W-2 is the tail flag.
// Optional feature: define VCBUF_BYPASS_EN to let a flit that arrives at an empty VC
// compete for the output in its arrival cycle. A granted bypass flit skips the FIFO.
module router_vc_input_buffer #(
  parameter int  DATA_W  = 35,
  parameter int  NUM_VC  = 2,
  parameter int  DEPTH   = 4,
  parameter int  CREDITS = 4,
  localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input logic                     clk,
  input logic                     RST_,
  router_vc_input_buffer_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

  // Registered state
  logic [DATA_W-1:0] mem    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  credit [NUM_VC];
  logic [NUM_VC-1:0] lock_q;
  logic [VC_W-1:0]   rr_last;
  logic              err_q;
  logic [DATA_W-1:0] odata_q;
  logic              ovalid_q;
  logic [VC_W-1:0]   ovch_q;
  logic [NUM_VC-1:0] oack_q;

  // Combinational decode
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] full;
  logic              vc_ok;
  logic              wr_accept;
  logic              wr_drop;
  logic              in_head;
  logic              in_tail;
  logic [DATA_W-1:0] front_flit [NUM_VC];
  logic [NUM_VC-1:0] front_valid;
  logic [NUM_VC-1:0] bypass_vc;
  logic [NUM_VC-1:0] eligible;
  logic              grant_valid;
  logic [VC_W-1:0]   grant_vc;
  logic [DATA_W-1:0] grant_flit;
  logic              grant_bypass;
  logic              push;
  logic [NUM_VC-1:0] grant_oh;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] credit_ovf;

  // Occupancy from registered pointers: equal pointers mean empty, differing MSBs mean full
  // NOTE: every always_comb output gets a default before any branch; a missed path infers a latch.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v] = (wr_ptr[v] == rd_ptr[v]);
      full[v]  = (wr_ptr[v][ADDR_W] != rd_ptr[v][ADDR_W]) &&
                 (wr_ptr[v][ADDR_W-1:0] == rd_ptr[v][ADDR_W-1:0]);
    end
  end

  // Write acceptance: a valid VC index with a non-full FIFO, otherwise the flit is dropped
  always_comb begin
    vc_ok     = (int'(bus.IVCH) < NUM_VC);
    wr_accept = bus.IVALID && vc_ok && !full[bus.IVCH];
    wr_drop   = bus.IVALID && !wr_accept;
    in_head   = bus.IDATA[DATA_W-1];
    in_tail   = bus.IDATA[DATA_W-2];
  end

  // Front flit of each VC and its eligibility for the output
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      front_valid[v] = !empty[v];
      front_flit[v]  = mem[v][rd_ptr[v][ADDR_W-1:0]];
      bypass_vc[v]   = 1'b0;
`ifdef VCBUF_BYPASS_EN
      if (empty[v] && wr_accept && (int'(bus.IVCH) == v)) begin
        front_valid[v] = 1'b1;
        front_flit[v]  = bus.IDATA;
        bypass_vc[v]   = 1'b1;
      end
`endif
      // A downstream lock blocks only new packets; body and tail flits keep flowing
      eligible[v] = front_valid[v] && (credit[v] != '0) &&
                    (!front_flit[v][DATA_W-1] || !bus.ILCK[v]);
    end
  end

  // Round-robin search beginning one past the last granted VC
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_vc    = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = (int'(rr_last) + i) % NUM_VC;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_vc    = VC_W'(idx);
      end
    end
  end

  // Grant side effects: pop, bypass write suppression and credit overflow detection
  always_comb begin
    grant_flit   = front_flit[grant_vc];
    grant_bypass = grant_valid && bypass_vc[grant_vc];
    push         = wr_accept && !grant_bypass;
    for (int v = 0; v < NUM_VC; v++) begin
      grant_oh[v]   = grant_valid && (int'(grant_vc) == v);
      pop[v]        = grant_oh[v] && !bypass_vc[v];
      credit_ovf[v] = bus.IACK[v] && !grant_oh[v] && (credit[v] == CREDIT_MAX);
    end
  end

  // FIFO pointers advance on push and pop
  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push && (int'(bus.IVCH) == v)) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])                        rd_ptr[v] <= rd_ptr[v] + 1'b1;
      end
    end
  end

  // FIFO storage writes
  // NOTE: the flit storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[bus.IVCH][wr_ptr[bus.IVCH][ADDR_W-1:0]] <= bus.IDATA;
  end

  // Downstream credits: a grant consumes one credit and IACK returns one credit
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      for (int v = 0; v < NUM_VC; v++) credit[v] <= CREDIT_MAX;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case ({grant_oh[v], bus.IACK[v]})
          2'b10:   credit[v] <= credit[v] - 1'b1;
          2'b01:   if (credit[v] != CREDIT_MAX) credit[v] <= credit[v] + 1'b1;
          default: credit[v] <= credit[v];
        endcase
      end
    end
  end

  // Packet lock tracking on accepted writes, plus the sticky error flag
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      lock_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        // A head flit that arrives while the lock is set is an error, and the lock stays set
        if (wr_accept && (int'(bus.IVCH) == v) && !(in_head && lock_q[v])) begin
          if (in_head && !in_tail) lock_q[v] <= 1'b1;
          else if (in_tail)        lock_q[v] <= 1'b0;
        end
      end
      if (wr_drop || (wr_accept && in_head && lock_q[bus.IVCH]) || (|credit_ovf))
        err_q <= 1'b1;
    end
  end

  // Registered output flit, upstream slot-free pulse and round-robin pointer
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      oack_q   <= '0;
      rr_last  <= VC_W'(NUM_VC - 1);
    end else begin
      ovalid_q <= grant_valid;
      oack_q   <= grant_oh;
      if (grant_valid) begin
        odata_q <= grant_flit;
        ovch_q  <= grant_vc;
        rr_last <= grant_vc;
      end
    end
  end

  assign bus.ORDY   = ~full;
  assign bus.OLCK   = lock_q;
  assign bus.OACK   = oack_q;
  assign bus.ODATA  = odata_q;
  assign bus.OVALID = ovalid_q;
  assign bus.OVCH   = ovch_q;
  assign bus.ERR    = err_q;
endmodule

// File: tb/tb_router_vc_input_buffer.sv
// Self-checking bench for router_vc_input_buffer (default parameters).
// The stimulus pushes the expected output flits into a queue, and a negedge monitor
// pops that queue and compares each flit when OVALID is high.
module tb_router_vc_input_buffer;
  localparam int DATA_W = 35;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;
`ifdef VCBUF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [VC_W-1:0]   vc;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic RST_;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   out_cnt;
  int   out_cyc [$];
  exp_t exp_q [$];

  router_vc_input_buffer_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC)) vif ();

  router_vc_input_buffer #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(4), .CREDITS(4)) dut (
    .clk  (clk),
    .RST_ (RST_),
    .bus  (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output scoreboard: every OVALID cycle must match the next expected flit
  always @(negedge clk) begin
    if (RST_ === 1'b1 && vif.OVALID === 1'b1) begin
      out_cnt++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_ovalid", vif.OVALID, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("odata", vif.ODATA, e.data);
        check("ovch", vif.OVCH, e.vc);
        check("oack", vif.OACK, 64'(1) << e.vc);
      end
    end
  end

  function automatic logic [DATA_W-1:0] mk(input logic h, input logic t, input logic [DATA_W-3:0] p);
    return {h, t, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [VC_W-1:0] vc, input logic [DATA_W-1:0] d, input bit expect_out);
    vif.IVALID = 1'b1;
    vif.IVCH   = vc;
    vif.IDATA  = d;
    if (expect_out) exp_q.push_back('{vc: vc, data: d});
  endtask

  task automatic idle();
    vif.IVALID = 1'b0;
    vif.IDATA  = '0;
    vif.IVCH   = '0;
  endtask

  task automatic wait_out(input int target, input int budget);
    int n;
    n = 0;
    while (out_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_out_count", out_cnt, target);
  endtask

  task automatic do_reset();
    idle();
    vif.IACK = '0;
    vif.ILCK = '0;
    RST_ = 1'b0;
    repeat (2) tick();
    RST_ = 1'b1;
    exp_q.delete();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int c0;
    n_checks = 0;
    n_errors = 0;
    out_cnt  = 0;
    cyc      = 0;
    RST_     = 1'b1;
    idle();
    vif.IACK = '0;
    vif.ILCK = '0;
    #2;
    do_reset();

    // Reset values
    check("rst_ordy", vif.ORDY, 2'b11);
    check("rst_olck", vif.OLCK, 2'b00);
    check("rst_oack", vif.OACK, 2'b00);
    check("rst_ovalid", vif.OVALID, 0);
    check("rst_odata", vif.ODATA, 0);
    check("rst_ovch", vif.OVCH, 0);
    check("rst_err", vif.ERR, 0);

    // Single-flit packet on VC1
    base = out_cnt;
    drive(1, mk(1'b1, 1'b1, 33'h12345678), 1);
    c0 = cyc;
    tick();
    idle();
    check("single_olck", vif.OLCK, 2'b00);
    wait_out(base + 1, 10);
    check("single_latency", out_cyc[base] - c0, LAT);
    check("single_olck_after", vif.OLCK, 2'b00);
    // One credit was consumed on VC1, so returning one must not raise an overflow
    vif.IACK = 2'b10;
    tick();
    vif.IACK = 2'b00;
    tick();
    check("single_credit_return_err", vif.ERR, 0);

    // 4-flit packet on VC0, then a fifth flit that must wait for a credit
    base = out_cnt;
    drive(0, mk(1'b1, 1'b0, 33'h100), 1);
    c0 = cyc;
    tick();
    check("pkt_olck_head", vif.OLCK, 2'b01);
    drive(0, mk(1'b0, 1'b0, 33'h101), 1);
    tick();
    check("pkt_olck_body", vif.OLCK, 2'b01);
    drive(0, mk(1'b0, 1'b0, 33'h102), 1);
    tick();
    drive(0, mk(1'b0, 1'b1, 33'h103), 1);
    tick();
    check("pkt_olck_tail", vif.OLCK, 2'b00);
    drive(0, mk(1'b1, 1'b1, 33'h104), 1);
    tick();
    idle();
    wait_out(base + 4, 20);
    check("pkt_latency", out_cyc[base] - c0, LAT);
    check("pkt_back_to_back", out_cyc[base + 3] - out_cyc[base], 3);
    repeat (4) tick();
    check("pkt_fifth_held", out_cnt, base + 4);
    vif.IACK = 2'b01;
    c0 = cyc;
    tick();
    vif.IACK = 2'b00;
    wait_out(base + 5, 10);
    check("pkt_fifth_after_credit", (out_cyc[base + 4] - c0 >= 1) && (out_cyc[base + 4] - c0 <= 2), 1);

    // VC0 is out of credits: fill its FIFO, overflow it, then drain
    base = out_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(0, mk(1'b1, 1'b1, 33'h200 + 33'(i)), 1);
      tick();
    end
    check("fill_ordy_full", vif.ORDY, 2'b10);
    check("fill_err_before", vif.ERR, 0);
    drive(0, mk(1'b1, 1'b1, 33'h2FF), 0);
    tick();
    idle();
    check("fill_err_drop", vif.ERR, 1);
    check("fill_ordy_vc1", vif.ORDY, 2'b10);
    check("fill_no_output", out_cnt, base);
    for (int i = 0; i < 4; i++) begin
      vif.IACK = 2'b01;
      tick();
    end
    vif.IACK = 2'b00;
    wait_out(base + 4, 30);
    repeat (4) tick();
    check("fill_drained_count", out_cnt, base + 4);
    check("fill_ordy_after", vif.ORDY, 2'b11);

    // Three flits on each VC held by ILCK, then released: output VCs alternate 0,1,0,1,0,1
    do_reset();
    base = out_cnt;
    vif.ILCK = 2'b11;
    for (int i = 0; i < 6; i++) begin
      drive(VC_W'(i % 2), mk(1'b1, 1'b1, 33'h300 + 33'(i)), 1);
      tick();
    end
    idle();
    tick();
    check("rr_held_by_ilck", out_cnt, base);
    vif.ILCK = 2'b00;
    wait_out(base + 6, 20);
    check("rr_back_to_back", out_cyc[base + 5] - out_cyc[base], 5);

    // ILCK[0] blocks the head on VC0 while the body flit on VC1 proceeds
    base = out_cnt;
    vif.ILCK = 2'b01;
    drive(0, mk(1'b1, 1'b0, 33'h400), 0);
    tick();
    drive(1, mk(1'b0, 1'b0, 33'h401), 1);
    tick();
    idle();
    exp_q.push_back('{vc: 1'b0, data: mk(1'b1, 1'b0, 33'h400)});
    wait_out(base + 1, 10);
    repeat (3) tick();
    check("ilck_vc0_blocked", out_cnt, base + 1);
    check("ilck_olck", vif.OLCK, 2'b01);
    vif.ILCK = 2'b00;
    c0 = cyc;
    wait_out(base + 2, 10);
    check("ilck_release_latency", out_cyc[base + 1] - c0, 1);

    // Asynchronous reset with two flits buffered and locks open
    base = out_cnt;
    vif.ILCK = 2'b11;
    drive(1, mk(1'b1, 1'b0, 33'h500), 0);
    tick();
    drive(1, mk(1'b0, 1'b0, 33'h501), 0);
    tick();
    idle();
    check("midrst_olck_before", vif.OLCK, 2'b11);
    check("midrst_odata_before", vif.ODATA, mk(1'b1, 1'b0, 33'h400));
    #3;
    RST_ = 1'b0;
    #1;
    check("midrst_ordy", vif.ORDY, 2'b11);
    check("midrst_olck", vif.OLCK, 2'b00);
    check("midrst_ovalid", vif.OVALID, 0);
    check("midrst_odata", vif.ODATA, 0);
    check("midrst_ovch", vif.OVCH, 0);
    check("midrst_err", vif.ERR, 0);
    vif.ILCK = 2'b00;
    tick();
    tick();
    RST_ = 1'b1;
    exp_q.delete();
    repeat (8) tick();
    check("midrst_no_output", out_cnt, base);
    check("midrst_ordy_after", vif.ORDY, 2'b11);

    // Returning a credit to a VC that already has all its credits sets ERR
    check("ovf_err_before", vif.ERR, 0);
    vif.IACK = 2'b10;
    tick();
    vif.IACK = 2'b00;
    tick();
    check("ovf_err", vif.ERR, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
